// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite to native bridge: response codes,
// controller state encoding and a small state-classification helper.
package axil_pkg;

    localparam logic [1:0] AXIL_OKAY   = 2'b00;
    localparam logic [1:0] AXIL_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_WR_RESP = 3'd3,
        ST_RD_RESP = 3'd4
    } axil_state_e;

    // True while a native request is outstanding.
    function automatic logic is_req_state(input axil_state_e st);
        return (st == ST_WR_REQ) || (st == ST_RD_REQ);
    endfunction

endpackage

// File: rtl/axil2native_bridge_if.sv
// AXI4-Lite channel bundle. The bridge connects through the slave modport,
// the traffic source through the master modport.
interface axil2native_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axil_hold_reg.sv
// Single-entry holding buffer for one AXI4-Lite request channel.
// Accepts on in_valid && in_ready, stays full until clear, and exposes a
// registered ready that is low during reset and equals !full afterwards.
module axil_hold_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clear,
    output logic             full,
    output logic [WIDTH-1:0] out_data
);

    logic             full_r;
    logic             full_n_s;
    logic             ready_r;
    logic [WIDTH-1:0] data_r;

    // Next occupancy: a grant empties the entry, an accepted beat fills it.
    always_comb begin
        full_n_s = full_r;
        if (clear) begin
            full_n_s = 1'b0;
        end else if (in_valid && ready_r) begin
            full_n_s = 1'b1;
        end else begin
            full_n_s = full_r;
        end
    end

    // Occupancy, ready and payload registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_r  <= 1'b0;
            ready_r <= 1'b0;
            data_r  <= {WIDTH{1'b0}};
        end else begin
            full_r  <= full_n_s;
            ready_r <= ~full_n_s;
            if (in_valid && ready_r) begin
                data_r <= in_data;
            end
        end
    end

    assign in_ready = ready_r;
    assign full     = full_r;
    assign out_data = data_r;

endmodule

// File: rtl/axil2native_bridge.sv
// AXI4-Lite slave to native master bridge. AW, W and AR are buffered
// independently; reads and writes are arbitrated fairly on ties and a single
// native request is issued at a time from registers. Responses are held until
// the AXI master accepts them.
// Optional feature macro: AXIL2NATIVE_TIMEOUT_EN adds a native-side timeout
// that completes a stalled request with SLVERR and zero read data.
module axil2native_bridge #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    axil2native_bridge_if.slave   s_axil,
    output logic                  native_valid,
    input  logic                  native_ready,
    output logic [ADDR_WIDTH-1:0] native_addr,
    output logic [DATA_WIDTH-1:0] native_wdata,
    output logic [STRB_WIDTH-1:0] native_wstrb,
    input  logic [DATA_WIDTH-1:0] native_rdata
);
    import axil_pkg::*;

    localparam int WBUF_W = DATA_WIDTH + STRB_WIDTH;

    logic                  aw_ready_s, w_ready_s, ar_ready_s;
    logic                  aw_full_s, w_full_s, ar_full_s;
    logic [ADDR_WIDTH-1:0] aw_q_s, ar_q_s;
    logic [WBUF_W-1:0]     w_q_s;

    axil_state_e           state_r, state_n_s;
    logic                  grant_wr_s, grant_rd_s;
    logic                  wr_cand_s, rd_cand_s;
    logic                  last_wr_r;
    logic                  timeout_s;

    logic                  native_valid_r;
    logic [ADDR_WIDTH-1:0] native_addr_r;
    logic [DATA_WIDTH-1:0] native_wdata_r;
    logic [STRB_WIDTH-1:0] native_wstrb_r;
    logic                  bvalid_r, rvalid_r;
    logic [1:0]            resp_r;
    logic [DATA_WIDTH-1:0] rdata_r;

    axil_hold_reg #(.WIDTH(ADDR_WIDTH)) u_aw_hold (
        .clk      (clk),
        .rst      (rst),
        .in_valid (s_axil.awvalid),
        .in_ready (aw_ready_s),
        .in_data  (s_axil.awaddr),
        .clear    (grant_wr_s),
        .full     (aw_full_s),
        .out_data (aw_q_s)
    );

    axil_hold_reg #(.WIDTH(WBUF_W)) u_w_hold (
        .clk      (clk),
        .rst      (rst),
        .in_valid (s_axil.wvalid),
        .in_ready (w_ready_s),
        .in_data  ({s_axil.wdata, s_axil.wstrb}),
        .clear    (grant_wr_s),
        .full     (w_full_s),
        .out_data (w_q_s)
    );

    axil_hold_reg #(.WIDTH(ADDR_WIDTH)) u_ar_hold (
        .clk      (clk),
        .rst      (rst),
        .in_valid (s_axil.arvalid),
        .in_ready (ar_ready_s),
        .in_data  (s_axil.araddr),
        .clear    (grant_rd_s),
        .full     (ar_full_s),
        .out_data (ar_q_s)
    );

    assign wr_cand_s = aw_full_s & w_full_s;
    assign rd_cand_s = ar_full_s;

`ifdef AXIL2NATIVE_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    localparam logic [TIMEOUT_W-1:0] TO_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

    logic [TIMEOUT_W-1:0] to_cnt_r;

    // Stall counter: restarts on each grant, counts REQ cycles without ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_r <= {TIMEOUT_W{1'b0}};
        end else if (grant_wr_s || grant_rd_s) begin
            to_cnt_r <= {TIMEOUT_W{1'b0}};
        end else if (is_req_state(state_r) && !native_ready) begin
            to_cnt_r <= to_cnt_r + TO_ONE;
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end

    // Expire on the edge where the counter would reach all-ones.
    assign timeout_s = is_req_state(state_r) && !native_ready && (to_cnt_r == TO_LAST);
`else
    assign timeout_s = 1'b0;
`endif

    // Controller state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Arbitration and next-state logic; a tie goes against last_wr_r.
    always_comb begin
        state_n_s  = state_r;
        grant_wr_s = 1'b0;
        grant_rd_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (wr_cand_s && (!rd_cand_s || !last_wr_r)) begin
                    grant_wr_s = 1'b1;
                    state_n_s  = ST_WR_REQ;
                end else if (rd_cand_s) begin
                    grant_rd_s = 1'b1;
                    state_n_s  = ST_RD_REQ;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_WR_REQ: begin
                if (native_ready || timeout_s) begin
                    state_n_s = ST_WR_RESP;
                end else begin
                    state_n_s = ST_WR_REQ;
                end
            end
            ST_RD_REQ: begin
                if (native_ready || timeout_s) begin
                    state_n_s = ST_RD_RESP;
                end else begin
                    state_n_s = ST_RD_REQ;
                end
            end
            ST_WR_RESP: begin
                if (s_axil.bready) begin
                    state_n_s = ST_IDLE;
                end else begin
                    state_n_s = ST_WR_RESP;
                end
            end
            ST_RD_RESP: begin
                if (s_axil.rready) begin
                    state_n_s = ST_IDLE;
                end else begin
                    state_n_s = ST_RD_RESP;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // Fairness flag: only a contested grant records who won.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_wr_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && wr_cand_s && rd_cand_s) begin
            last_wr_r <= grant_wr_s;
        end else begin
            last_wr_r <= last_wr_r;
        end
    end

    // Native request registers, loaded at grant and held stable through REQ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            native_valid_r <= 1'b0;
            native_addr_r  <= {ADDR_WIDTH{1'b0}};
            native_wdata_r <= {DATA_WIDTH{1'b0}};
            native_wstrb_r <= {STRB_WIDTH{1'b0}};
        end else begin
            native_valid_r <= is_req_state(state_n_s);
            if (grant_wr_s) begin
                native_addr_r  <= aw_q_s;
                native_wdata_r <= w_q_s[WBUF_W-1:STRB_WIDTH];
                native_wstrb_r <= w_q_s[STRB_WIDTH-1:0];
            end else if (grant_rd_s) begin
                native_addr_r  <= ar_q_s;
                native_wdata_r <= {DATA_WIDTH{1'b0}};
                native_wstrb_r <= {STRB_WIDTH{1'b0}};
            end
        end
    end

    // Response registers: captured when the native side completes or expires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bvalid_r <= 1'b0;
            rvalid_r <= 1'b0;
            resp_r   <= AXIL_OKAY;
            rdata_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            bvalid_r <= (state_n_s == ST_WR_RESP);
            rvalid_r <= (state_n_s == ST_RD_RESP);
            if (is_req_state(state_r) && native_ready) begin
                resp_r <= AXIL_OKAY;
                if (state_r == ST_RD_REQ) begin
                    rdata_r <= native_rdata;
                end
            end else if (timeout_s) begin
                resp_r  <= AXIL_SLVERR;
                rdata_r <= {DATA_WIDTH{1'b0}};
            end
        end
    end

    assign s_axil.awready = aw_ready_s;
    assign s_axil.wready  = w_ready_s;
    assign s_axil.arready = ar_ready_s;
    assign s_axil.bvalid  = bvalid_r;
    assign s_axil.bresp   = resp_r;
    assign s_axil.rvalid  = rvalid_r;
    assign s_axil.rresp   = resp_r;
    assign s_axil.rdata   = rdata_r;

    assign native_valid = native_valid_r;
    assign native_addr  = native_addr_r;
    assign native_wdata = native_wdata_r;
    assign native_wstrb = native_wstrb_r;

endmodule

// File: tb/tb_axil2native_bridge.sv
// Directed plus randomized bench for axil2native_bridge. A native responder
// returns address-derived read data with selectable ready behaviour; a monitor
// logs every accepted native request for comparison against expectations.
module tb_axil2native_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
`ifdef AXIL2NATIVE_TIMEOUT_EN
    localparam int TW = 4;
`else
    localparam int TW = 8;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        native_valid;
    logic        native_ready;
    logic [31:0] native_addr;
    logic [31:0] native_wdata;
    logic [3:0]  native_wstrb;
    logic [31:0] native_rdata;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          ready_mode = 0;        // 0 low, 1 high, 2 random
    bit          rdata_force = 1'b1;
    logic [31:0] forced_rdata = 32'h0;
    req_t        reqs[$];

    axil2native_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) axil ();

    axil2native_bridge #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .TIMEOUT_W(TW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axil       (axil),
        .native_valid (native_valid),
        .native_ready (native_ready),
        .native_addr  (native_addr),
        .native_wdata (native_wdata),
        .native_wstrb (native_wstrb),
        .native_rdata (native_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (native_valid && native_ready) reqs.push_back({native_addr, native_wdata, native_wstrb});
    end

    function automatic logic [31:0] slave_data(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h0101};
    endfunction

    // Native responder: applies ready mode and read data just after each negedge.
    initial begin
        native_ready = 1'b0;
        native_rdata = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            if (ready_mode == 2) native_ready = ($urandom_range(0, 3) != 0);
            else                 native_ready = (ready_mode == 1);
            native_rdata = rdata_force ? forced_rdata : slave_data(native_addr);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Raise the selected request channels and drop each one after its handshake.
    task automatic present(input bit do_aw, input bit do_w, input bit do_ar,
                           input logic [31:0] aa, input logic [31:0] wd,
                           input logic [3:0] ws, input logic [31:0] ra);
        bit pa, pw, pr, ha, hw, hr;
        int n;
        pa = do_aw; pw = do_w; pr = do_ar; n = 0;
        if (do_aw) begin axil.awaddr = aa; axil.awprot = 3'($urandom_range(0, 7)); axil.awvalid = 1'b1; end
        if (do_w)  begin axil.wdata = wd; axil.wstrb = ws; axil.wvalid = 1'b1; end
        if (do_ar) begin axil.araddr = ra; axil.arprot = 3'($urandom_range(0, 7)); axil.arvalid = 1'b1; end
        while ((pa || pw || pr) && n < 60) begin
            ha = pa && axil.awready;
            hw = pw && axil.wready;
            hr = pr && axil.arready;
            @(negedge clk);
            n++;
            if (ha) begin pa = 1'b0; axil.awvalid = 1'b0; end
            if (hw) begin pw = 1'b0; axil.wvalid = 1'b0; end
            if (hr) begin pr = 1'b0; axil.arvalid = 1'b0; end
        end
        chk("present_accepted", 64'(pa || pw || pr), 64'd0);
    endtask

    task automatic take_b(input int dly, input logic [1:0] exp_resp, input string tag);
        int n;
        n = 0;
        while (!axil.bvalid && n < 100) begin @(negedge clk); n++; end
        chk({tag, "_bvalid"}, 64'(axil.bvalid), 64'd1);
        chk({tag, "_bresp"}, 64'(axil.bresp), 64'(exp_resp));
        tick(dly);
        axil.bready = 1'b1;
        @(negedge clk);
        axil.bready = 1'b0;
        chk({tag, "_bdone"}, 64'(axil.bvalid), 64'd0);
    endtask

    task automatic take_r(input int dly, input logic [31:0] exp_data, input logic [1:0] exp_resp,
                          input string tag);
        int n;
        n = 0;
        while (!axil.rvalid && n < 100) begin @(negedge clk); n++; end
        chk({tag, "_rvalid"}, 64'(axil.rvalid), 64'd1);
        chk({tag, "_rdata"}, 64'(axil.rdata), 64'(exp_data));
        chk({tag, "_rresp"}, 64'(axil.rresp), 64'(exp_resp));
        tick(dly);
        axil.rready = 1'b1;
        @(negedge clk);
        axil.rready = 1'b0;
        chk({tag, "_rdone"}, 64'(axil.rvalid), 64'd0);
    endtask

    task automatic wait_nv(input string tag);
        int n;
        n = 0;
        while (!native_valid && n < 100) begin @(negedge clk); n++; end
        chk(tag, 64'(native_valid), 64'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_bvalid"}, 64'(axil.bvalid), 64'd0);
        chk({tag, "_rvalid"}, 64'(axil.rvalid), 64'd0);
        chk({tag, "_bresp"}, 64'(axil.bresp), 64'd0);
        chk({tag, "_rresp"}, 64'(axil.rresp), 64'd0);
        chk({tag, "_rdata"}, 64'(axil.rdata), 64'd0);
        chk({tag, "_nvalid"}, 64'(native_valid), 64'd0);
        chk({tag, "_naddr"}, 64'(native_addr), 64'd0);
        chk({tag, "_nwdata"}, 64'(native_wdata), 64'd0);
        chk({tag, "_nwstrb"}, 64'(native_wstrb), 64'd0);
    endtask

    initial begin
        int t_hs, n, cnt;
        bit is_wr;
        logic [31:0] a, d;
        logic [3:0]  s;
        int order;

        axil.awaddr = 32'h0; axil.awprot = 3'd0; axil.awvalid = 1'b0;
        axil.wdata  = 32'h0; axil.wstrb  = 4'h0; axil.wvalid  = 1'b0;
        axil.bready = 1'b0;
        axil.araddr = 32'h0; axil.arprot = 3'd0; axil.arvalid = 1'b0;
        axil.rready = 1'b0;

        // Reset state
        @(negedge clk);
        chk_all_zero("rst");
        chk("rst_awready", 64'(axil.awready), 64'd0);
        chk("rst_wready", 64'(axil.wready), 64'd0);
        chk("rst_arready", 64'(axil.arready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_awready", 64'(axil.awready), 64'd1);
        chk("post_rst_arready", 64'(axil.arready), 64'd1);

        // Write data before address, native always ready
        ready_mode = 1;
        reqs.delete();
        present(1'b0, 1'b1, 1'b0, 32'h0, 32'hDEADBEEF, 4'hF, 32'h0);
        for (int i = 0; i < 2; i++) begin
            chk("w_only_no_req", 64'(native_valid), 64'd0);
            chk("w_only_wready", 64'(axil.wready), 64'd0);
            @(negedge clk);
        end
        present(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 32'h0);
        t_hs = cyc;
        n = 0;
        while (!axil.bvalid && n < 20) begin @(negedge clk); n++; end
        chk("wr_latency", 64'(cyc - t_hs), 64'd2);
        chk("wr_nreq", 64'(reqs.size()), 64'd1);
        chk("wr_naddr", 64'(reqs[0].addr), 64'h100);
        chk("wr_nwdata", 64'(reqs[0].wdata), 64'hDEADBEEF);
        chk("wr_nwstrb", 64'(reqs[0].wstrb), 64'hF);
        take_b(0, 2'b00, "wr1");

        // Read with native ready withheld for four cycles
        ready_mode = 0;
        rdata_force = 1'b1;
        forced_rdata = 32'h12345678;
        reqs.delete();
        present(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h40);
        wait_nv("rd_nvalid_rise");
        chk("rd_naddr", 64'(native_addr), 64'h40);
        chk("rd_nwdata", 64'(native_wdata), 64'd0);
        for (int i = 1; i <= 5; i++) begin
            chk("rd_nvalid_held", 64'(native_valid), 64'd1);
            chk("rd_nwstrb", 64'(native_wstrb), 64'd0);
            if (i == 5) ready_mode = 1;
            @(negedge clk);
        end
        ready_mode = 0;
        chk("rd_nvalid_drop", 64'(native_valid), 64'd0);
        take_r(1, 32'h12345678, 2'b00, "rd1");

        // Tie arbitration, twice
        ready_mode = 1;
        axil.bready = 1'b1;
        axil.rready = 1'b1;
        for (int round = 0; round < 2; round++) begin
            reqs.delete();
            present(1'b1, 1'b1, 1'b1, 32'h300 + 32'(round), 32'hA5A50000 + 32'(round), 4'h5,
                    32'h500 + 32'(round));
            n = 0;
            while (reqs.size() < 2 && n < 40) begin @(negedge clk); n++; end
            tick(3);
            chk("tie_nreq", 64'(reqs.size()), 64'd2);
            if (round == 0) begin
                chk("tie0_first_addr", 64'(reqs[0].addr), 64'h300);
                chk("tie0_first_strb", 64'(reqs[0].wstrb), 64'h5);
                chk("tie0_second_addr", 64'(reqs[1].addr), 64'h500);
                chk("tie0_second_strb", 64'(reqs[1].wstrb), 64'h0);
            end else begin
                chk("tie1_first_addr", 64'(reqs[0].addr), 64'h501);
                chk("tie1_first_strb", 64'(reqs[0].wstrb), 64'h0);
                chk("tie1_second_addr", 64'(reqs[1].addr), 64'h301);
                chk("tie1_second_wdata", 64'(reqs[1].wdata), 64'hA5A50001);
            end
            chk("tie_idle_b", 64'(axil.bvalid), 64'd0);
            chk("tie_idle_r", 64'(axil.rvalid), 64'd0);
        end
        axil.bready = 1'b0;
        axil.rready = 1'b0;

        // Back-pressure on B with a second write queued
        reqs.delete();
        present(1'b1, 1'b1, 1'b0, 32'h600, 32'h11111111, 4'hF, 32'h0);
        n = 0;
        while (!axil.bvalid && n < 20) begin @(negedge clk); n++; end
        present(1'b1, 1'b1, 1'b0, 32'h604, 32'h22222222, 4'hC, 32'h0);
        chk("bp_awready_full", 64'(axil.awready), 64'd0);
        chk("bp_wready_full", 64'(axil.wready), 64'd0);
        for (int i = 0; i < 10; i++) begin
            chk("bp_no_second_req", 64'(native_valid), 64'd0);
            chk("bp_bvalid_held", 64'(axil.bvalid), 64'd1);
            @(negedge clk);
        end
        chk("bp_nreq_before", 64'(reqs.size()), 64'd1);
        take_b(0, 2'b00, "bp1");
        wait_nv("bp_second_nvalid");
        take_b(0, 2'b00, "bp2");
        chk("bp_nreq_after", 64'(reqs.size()), 64'd2);
        chk("bp_second_addr", 64'(reqs[1].addr), 64'h604);
        chk("bp_second_data", 64'(reqs[1].wdata), 64'h22222222);
        chk("bp_second_strb", 64'(reqs[1].wstrb), 64'hC);

`ifdef AXIL2NATIVE_TIMEOUT_EN
        // Native side never answers
        ready_mode = 0;
        forced_rdata = 32'hFFFFFFFF;
        present(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h80);
        wait_nv("to_nvalid_rise");
        cnt = 0;
        while (native_valid && cnt < 40) begin cnt++; @(negedge clk); end
        chk("to_valid_cycles", 64'(cnt), 64'd15);
        take_r(0, 32'h0, 2'b10, "to");
`endif

        // Reset in the middle of a read request
        ready_mode = 0;
        reqs.delete();
        present(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h44);
        wait_nv("mid_rst_nvalid");
        rst = 1'b1;
        #1;
        chk("mid_rst_nvalid_drop", 64'(native_valid), 64'd0);
        chk("mid_rst_naddr", 64'(native_addr), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("post_mid_rst");
        chk("post_mid_rst_arready", 64'(axil.arready), 64'd1);
        ready_mode = 1;
        tick(3);
        chk("post_mid_rst_no_r", 64'(axil.rvalid), 64'd0);
        chk("post_mid_rst_no_req", 64'(reqs.size()), 64'd0);
        present(1'b1, 1'b1, 1'b0, 32'h200, 32'hCAFEF00D, 4'h3, 32'h0);
        take_b(0, 2'b00, "fresh_wr");
        chk("fresh_nreq", 64'(reqs.size()), 64'd1);
        chk("fresh_addr", 64'(reqs[0].addr), 64'h200);
        chk("fresh_data", 64'(reqs[0].wdata), 64'hCAFEF00D);
        chk("fresh_strb", 64'(reqs[0].wstrb), 64'h3);

        // Randomized traffic against the request/response reference
        ready_mode = 2;
        rdata_force = 1'b0;
        for (int k = 0; k < 30; k++) begin
            reqs.delete();
            is_wr = 1'($urandom_range(0, 1));
            a = $urandom() & 32'hFFFFFFFC;
            if (is_wr) begin
                d = $urandom();
                s = 4'($urandom_range(1, 15));
                order = $urandom_range(0, 2);
                if (order == 0) begin
                    present(1'b1, 1'b1, 1'b0, a, d, s, 32'h0);
                end else if (order == 1) begin
                    present(1'b1, 1'b0, 1'b0, a, d, s, 32'h0);
                    tick($urandom_range(0, 3));
                    present(1'b0, 1'b1, 1'b0, a, d, s, 32'h0);
                end else begin
                    present(1'b0, 1'b1, 1'b0, a, d, s, 32'h0);
                    tick($urandom_range(0, 3));
                    present(1'b1, 1'b0, 1'b0, a, d, s, 32'h0);
                end
                take_b($urandom_range(0, 3), 2'b00, "rnd_wr");
                chk("rnd_wr_nreq", 64'(reqs.size()), 64'd1);
                chk("rnd_wr_addr", 64'(reqs[0].addr), 64'(a));
                chk("rnd_wr_data", 64'(reqs[0].wdata), 64'(d));
                chk("rnd_wr_strb", 64'(reqs[0].wstrb), 64'(s));
            end else begin
                present(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, a);
                take_r($urandom_range(0, 3), slave_data(a), 2'b00, "rnd_rd");
                chk("rnd_rd_nreq", 64'(reqs.size()), 64'd1);
                chk("rnd_rd_addr", 64'(reqs[0].addr), 64'(a));
                chk("rnd_rd_strb", 64'(reqs[0].wstrb), 64'd0);
                chk("rnd_rd_wdata", 64'(reqs[0].wdata), 64'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
